// File: rtl/ipd_pkg.sv
// Shared encodings for the iterated Prisoner's Dilemma blocks: actions, winner codes, FSM states.
package ipd_pkg;

  localparam logic ACT_COOP   = 1'b0;
  localparam logic ACT_DEFECT = 1'b1;

  localparam logic [1:0] WIN_TIE = 2'b00;
  localparam logic [1:0] WIN_A   = 2'b01;
  localparam logic [1:0] WIN_B   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ipd_payoff_lut.sv
// Combinational payoff lookup: {action_a, action_b} -> {pay_a, pay_b} from a parametrised matrix.
module ipd_payoff_lut
  import ipd_pkg::*;
#(
  parameter int PAY_W  = 32,
  parameter int PAY_CC = 5,
  parameter int PAY_CD = 1,
  parameter int PAY_DC = 4,
  parameter int PAY_DD = 2
) (
  input  logic             action_a,
  input  logic             action_b,
  output logic [PAY_W-1:0] pay_a,
  output logic [PAY_W-1:0] pay_b
);

  localparam logic [PAY_W-1:0] P_CC = PAY_W'(PAY_CC);
  localparam logic [PAY_W-1:0] P_CD = PAY_W'(PAY_CD);
  localparam logic [PAY_W-1:0] P_DC = PAY_W'(PAY_DC);
  localparam logic [PAY_W-1:0] P_DD = PAY_W'(PAY_DD);

  // Payoff matrix lookup
  always_comb begin
    pay_a = {PAY_W{1'b0}};
    pay_b = {PAY_W{1'b0}};
    case ({action_a, action_b})
      {ACT_COOP, ACT_COOP}: begin
        pay_a = P_CC;
        pay_b = P_CC;
      end
      {ACT_COOP, ACT_DEFECT}: begin
        pay_a = P_CD;
        pay_b = P_DC;
      end
      {ACT_DEFECT, ACT_COOP}: begin
        pay_a = P_DC;
        pay_b = P_CD;
      end
      {ACT_DEFECT, ACT_DEFECT}: begin
        pay_a = P_DD;
        pay_b = P_DD;
      end
      default: begin
        pay_a = {PAY_W{1'b0}};
        pay_b = {PAY_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/ipd_match_scorer.sv
// One iterated match of ROUNDS rounds: saturating scores, action counts, registered winner.
// Optional IPD_STREAK_TRACK_EN adds cur_streak/max_streak mutual-cooperation tracking.
module ipd_match_scorer
  import ipd_pkg::*;
#(
  parameter int SCORE_W = 32,
  parameter int ROUNDS  = 200,
  parameter int PAY_CC  = 5,
  parameter int PAY_CD  = 1,
  parameter int PAY_DC  = 4,
  parameter int PAY_DD  = 2,
  localparam int CNT_W  = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               act_valid,
  input  logic               action_A,
  input  logic               action_B,
  output logic               act_ready,
  output logic [SCORE_W-1:0] score_A,
  output logic [SCORE_W-1:0] score_B,
  output logic [CNT_W-1:0]   coop_A_cnt,
  output logic [CNT_W-1:0]   defect_A_cnt,
  output logic [CNT_W-1:0]   coop_B_cnt,
  output logic [CNT_W-1:0]   defect_B_cnt,
  output logic [CNT_W-1:0]   round_cnt,
  output logic               match_done,
`ifdef IPD_STREAK_TRACK_EN
  output logic [CNT_W-1:0]   cur_streak,
  output logic [CNT_W-1:0]   max_streak,
`endif
  output logic [1:0]         winner
);

  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [CNT_W-1:0]   coop_a_q, coop_a_d, defect_a_q, defect_a_d;
  logic [CNT_W-1:0]   coop_b_q, coop_b_d, defect_b_q, defect_b_d;
  logic [CNT_W-1:0]   round_q, round_d;
  logic [1:0]         winner_q, winner_d;
  logic               act_ready_q, act_ready_d;
  logic               match_done_q, match_done_d;

  logic [SCORE_W-1:0] pay_a_s, pay_b_s;
  logic [SCORE_W:0]   sum_a_s, sum_b_s;
  logic [SCORE_W-1:0] sat_a_s, sat_b_s;
  logic               accept_s, clear_s;

  ipd_payoff_lut #(
    .PAY_W (SCORE_W),
    .PAY_CC(PAY_CC),
    .PAY_CD(PAY_CD),
    .PAY_DC(PAY_DC),
    .PAY_DD(PAY_DD)
  ) u_lut (
    .action_a(action_A),
    .action_b(action_B),
    .pay_a   (pay_a_s),
    .pay_b   (pay_b_s)
  );

  assign accept_s = (state_q == S_PLAY) && act_valid;
  assign clear_s  = (state_q != S_PLAY) && start;

  // Saturating score adders: the carry-out selects the ceiling instead of wrapping
  always_comb begin
    sum_a_s = {1'b0, score_a_q} + {1'b0, pay_a_s};
    sum_b_s = {1'b0, score_b_q} + {1'b0, pay_b_s};
    if (sum_a_s[SCORE_W]) begin
      sat_a_s = SCORE_MAX;
    end else begin
      sat_a_s = sum_a_s[SCORE_W-1:0];
    end
    if (sum_b_s[SCORE_W]) begin
      sat_b_s = SCORE_MAX;
    end else begin
      sat_b_s = sum_b_s[SCORE_W-1:0];
    end
  end

  // Match FSM next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    coop_a_d   = coop_a_q;
    defect_a_d = defect_a_q;
    coop_b_d   = coop_b_q;
    defect_b_d = defect_b_q;
    round_d    = round_q;
    winner_d   = winner_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_PLAY;
          score_a_d  = {SCORE_W{1'b0}};
          score_b_d  = {SCORE_W{1'b0}};
          coop_a_d   = {CNT_W{1'b0}};
          defect_a_d = {CNT_W{1'b0}};
          coop_b_d   = {CNT_W{1'b0}};
          defect_b_d = {CNT_W{1'b0}};
          round_d    = {CNT_W{1'b0}};
          winner_d   = WIN_TIE;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        if (act_valid) begin
          score_a_d = sat_a_s;
          score_b_d = sat_b_s;
          round_d   = round_q + CNT_ONE;
          if (action_A == ACT_COOP) begin
            coop_a_d = coop_a_q + CNT_ONE;
          end else begin
            defect_a_d = defect_a_q + CNT_ONE;
          end
          if (action_B == ACT_COOP) begin
            coop_b_d = coop_b_q + CNT_ONE;
          end else begin
            defect_b_d = defect_b_q + CNT_ONE;
          end
          // Winner is captured on the same edge that enters DONE
          if (round_d == CNT_LAST) begin
            state_d = S_DONE;
            if (sat_a_s > sat_b_s) begin
              winner_d = WIN_A;
            end else if (sat_b_s > sat_a_s) begin
              winner_d = WIN_B;
            end else begin
              winner_d = WIN_TIE;
            end
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    act_ready_d  = (state_d == S_PLAY);
    match_done_d = (state_d == S_DONE);
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      score_a_q    <= {SCORE_W{1'b0}};
      score_b_q    <= {SCORE_W{1'b0}};
      coop_a_q     <= {CNT_W{1'b0}};
      defect_a_q   <= {CNT_W{1'b0}};
      coop_b_q     <= {CNT_W{1'b0}};
      defect_b_q   <= {CNT_W{1'b0}};
      round_q      <= {CNT_W{1'b0}};
      winner_q     <= WIN_TIE;
      act_ready_q  <= 1'b0;
      match_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      coop_a_q     <= coop_a_d;
      defect_a_q   <= defect_a_d;
      coop_b_q     <= coop_b_d;
      defect_b_q   <= defect_b_d;
      round_q      <= round_d;
      winner_q     <= winner_d;
      act_ready_q  <= act_ready_d;
      match_done_q <= match_done_d;
    end
  end

`ifdef IPD_STREAK_TRACK_EN
  logic [CNT_W-1:0] cur_streak_q, cur_streak_d, max_streak_q, max_streak_d;

  // Mutual-cooperation run tracking
  always_comb begin
    cur_streak_d = cur_streak_q;
    max_streak_d = max_streak_q;
    if (clear_s) begin
      cur_streak_d = {CNT_W{1'b0}};
      max_streak_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      if ((action_A == ACT_COOP) && (action_B == ACT_COOP)) begin
        cur_streak_d = cur_streak_q + CNT_ONE;
      end else begin
        cur_streak_d = {CNT_W{1'b0}};
      end
      if (cur_streak_d > max_streak_q) begin
        max_streak_d = cur_streak_d;
      end else begin
        max_streak_d = max_streak_q;
      end
    end else begin
      cur_streak_d = cur_streak_q;
    end
  end

  // Streak registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_streak_q <= {CNT_W{1'b0}};
      max_streak_q <= {CNT_W{1'b0}};
    end else begin
      cur_streak_q <= cur_streak_d;
      max_streak_q <= max_streak_d;
    end
  end

  assign cur_streak = cur_streak_q;
  assign max_streak = max_streak_q;
`else
  logic unused_s;
  assign unused_s = clear_s & accept_s;
`endif

  assign act_ready    = act_ready_q;
  assign match_done   = match_done_q;
  assign winner       = winner_q;
  assign score_A      = score_a_q;
  assign score_B      = score_b_q;
  assign coop_A_cnt   = coop_a_q;
  assign defect_A_cnt = defect_a_q;
  assign coop_B_cnt   = coop_b_q;
  assign defect_B_cnt = defect_b_q;
  assign round_cnt    = round_q;

endmodule

// File: tb/tb_ipd_match_scorer.sv
// Directed bench: u_m4 (32-bit scores, 4 rounds) and u_s6 (4-bit scores, 6 rounds, saturation).
module tb_ipd_match_scorer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, valid0 = 1'b0, start1 = 1'b0, valid1 = 1'b0;
  logic act_a = 1'b0, act_b = 1'b0;

  logic        ready0, done0, ready1, done1;
  logic [31:0] sa0, sb0;
  logic [3:0]  sa1, sb1;
  logic [2:0]  ca0, da0, cb0, db0, rc0, ca1, da1, cb1, db1, rc1;
  logic [1:0]  win0, win1;
`ifdef IPD_STREAK_TRACK_EN
  logic [2:0]  cur0, max0, cur1, max1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ipd_match_scorer #(.SCORE_W(32), .ROUNDS(4)) u_m4 (
    .clk(clk), .reset(reset), .start(start0), .act_valid(valid0),
    .action_A(act_a), .action_B(act_b), .act_ready(ready0),
    .score_A(sa0), .score_B(sb0), .coop_A_cnt(ca0), .defect_A_cnt(da0),
    .coop_B_cnt(cb0), .defect_B_cnt(db0), .round_cnt(rc0), .match_done(done0),
`ifdef IPD_STREAK_TRACK_EN
    .cur_streak(cur0), .max_streak(max0),
`endif
    .winner(win0)
  );

  ipd_match_scorer #(.SCORE_W(4), .ROUNDS(6)) u_s6 (
    .clk(clk), .reset(reset), .start(start1), .act_valid(valid1),
    .action_A(act_a), .action_B(act_b), .act_ready(ready1),
    .score_A(sa1), .score_B(sb1), .coop_A_cnt(ca1), .defect_A_cnt(da1),
    .coop_B_cnt(cb1), .defect_B_cnt(db1), .round_cnt(rc1), .match_done(done1),
`ifdef IPD_STREAK_TRACK_EN
    .cur_streak(cur1), .max_streak(max1),
`endif
    .winner(win1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic beat(input int sel, input logic a, input logic b);
    act_a = a;
    act_b = b;
    if (sel == 0) valid0 = 1'b1;
    else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic go(input int sel);
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("rst_score_A", sa0, 0);
    check("rst_ready", ready0, 0);
    check("rst_done", done0, 0);
    check("rst_winner", win0, 0);
    check("rst_round", rc0, 0);
    reset = 1'b0;

    // act_valid in IDLE is ignored
    beat(0, 1'b0, 1'b0);
    check("idle_valid_round", rc0, 0);
    go(0);
    check("play_ready", ready0, 1);

    // all cooperate: 5 per round each
    repeat (3) beat(0, 1'b0, 1'b0);
    check("cc3_score_A", sa0, 15);
    check("cc3_round", rc0, 3);
    check("cc3_done", done0, 0);
    beat(0, 1'b0, 1'b0);
    check("cc4_score_A", sa0, 20);
    check("cc4_score_B", sb0, 20);
    check("cc4_coop_A", ca0, 4);
    check("cc4_coop_B", cb0, 4);
    check("cc4_defect_A", da0, 0);
    check("cc4_done", done0, 1);
    check("cc4_winner", win0, 0);
    check("cc4_ready", ready0, 0);

    // act_valid in DONE is ignored
    beat(0, 1'b1, 1'b1);
    check("done_valid_round", rc0, 4);
    check("done_valid_score", sa0, 20);

    // start with act_valid in DONE: clear only
    start0 = 1'b1;
    beat(0, 1'b1, 1'b1);
    start0 = 1'b0;
    check("clr_round", rc0, 0);
    check("clr_score_A", sa0, 0);
    check("clr_done", done0, 0);
    check("clr_winner", win0, 0);
    check("clr_ready", ready0, 1);

    // 10,10,01,11 with gaps; start mid-play is ignored
    beat(0, 1'b1, 1'b0);
    idle(2);
    beat(0, 1'b1, 1'b0);
    go(0);
    check("mid_round", rc0, 2);
    check("mid_score_A", sa0, 8);
    check("mid_score_B", sb0, 2);
    idle(1);
    beat(0, 1'b0, 1'b1);
    beat(0, 1'b1, 1'b1);
    check("mix_score_A", sa0, 11);
    check("mix_score_B", sb0, 8);
    check("mix_defect_A", da0, 3);
    check("mix_coop_A", ca0, 1);
    check("mix_coop_B", cb0, 2);
    check("mix_defect_B", db0, 2);
    check("mix_round", rc0, 4);
    check("mix_winner", win0, 1);
    check("mix_done", done0, 1);

    // B wins: 01,01,00,00 -> A=12, B=18
    go(0);
    beat(0, 1'b0, 1'b1);
    beat(0, 1'b0, 1'b1);
    beat(0, 1'b0, 1'b0);
    beat(0, 1'b0, 1'b0);
    check("bwin_score_A", sa0, 12);
    check("bwin_score_B", sb0, 18);
    check("bwin_winner", win0, 2);

    // 4-bit saturation with all cooperate
    go(1);
    repeat (3) beat(1, 1'b0, 1'b0);
    check("sat3_score_A", sa1, 15);
    beat(1, 1'b0, 1'b0);
    check("sat4_score_A", sa1, 15);
    check("sat4_round", rc1, 4);
    repeat (2) beat(1, 1'b0, 1'b0);
    check("sat6_score_B", sb1, 15);
    check("sat6_done", done1, 1);
    check("sat6_winner", win1, 0);
    check("sat6_round", rc1, 6);

    // asynchronous reset mid-match
    go(1);
    beat(1, 1'b0, 1'b0);
    beat(1, 1'b0, 1'b0);
    check("pre_rst_score", sa1, 10);
    check("pre_rst_round", rc1, 2);
    #2 reset = 1'b1;
    #1;
    check("arst_round", rc1, 0);
    check("arst_score", sa1, 0);
    check("arst_ready", ready1, 0);
    check("arst_done", done1, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    beat(1, 1'b0, 1'b0);
    check("post_rst_idle_round", rc1, 0);

    // full 6-round rerun, A defects every round
    go(1);
    repeat (6) beat(1, 1'b1, 1'b0);
    check("dc6_score_A", sa1, 15);
    check("dc6_score_B", sb1, 6);
    check("dc6_defect_A", da1, 6);
    check("dc6_coop_B", cb1, 6);
    check("dc6_winner", win1, 1);
    check("dc6_done", done1, 1);

`ifdef IPD_STREAK_TRACK_EN
    go(1);
    beat(1, 1'b0, 1'b0);
    beat(1, 1'b0, 1'b0);
    beat(1, 1'b0, 1'b1);
    check("stk_mid_cur", cur1, 0);
    check("stk_mid_max", max1, 2);
    repeat (3) beat(1, 1'b0, 1'b0);
    check("stk_end_cur", cur1, 3);
    check("stk_end_max", max1, 3);
    go(1);
    check("stk_clr_cur", cur1, 0);
    check("stk_clr_max", max1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
